alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even and >=8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port opsel  input  4  operation select.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands.
REQ-008 SHALL have port out_valid  output  1  result, zero, carry and err hold a valid result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have ports result (output, WIDTH, result value), zero (output, 1, result==0), carry (output, 1, carry/borrow), err (output, 1, illegal opcode).

Function
REQ-011 SHALL accept a request on an edge where in_valid && in_ready, capturing opsel, a and b.
REQ-012 SHALL implement opcodes 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NAND; 6 NOR; 7 XNOR (all bitwise).
REQ-013 SHALL implement opcode 8 MVHI: result = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-014 SHALL implement opcodes 9 SLL, 10 SRL, 11 SRA; shift amount = b[$clog2(WIDTH)-1:0]; SRA fills with a[WIDTH-1].
REQ-015 SHALL implement opcodes 12 SLT (signed a<b) and 13 SLTU (unsigned a<b); result = 1 or 0, zero-extended.
REQ-016 SHALL implement opcode 14 MUL: low WIDTH bits of unsigned a*b, computed iteratively by shift-add, one bit per cycle.
REQ-017 SHALL treat opcode 15 as illegal: result 0, err 1, single-cycle latency.
REQ-018 SHALL set carry to the bit-WIDTH carry-out for ADD, to 1 for SUB exactly when a<b unsigned, and to 0 for all other opcodes.
REQ-019 SHALL set zero = (result == 0) for every opcode, including illegal.
REQ-020 SHALL use a state machine with states IDLE, BUSY and DONE.
REQ-021 IDLE: in_ready=1, out_valid=0; accepting a non-MUL request goes to DONE, accepting a MUL request goes to BUSY.
REQ-022 BUSY: in_ready=0, out_valid=0; after exactly WIDTH cycles in BUSY, go to DONE.
REQ-023 DONE: out_valid=1; result, zero, carry and err are held stable until the edge where out_ready=1.
REQ-024 DONE with out_ready=1: in_ready=1; a same-cycle accepted request goes to DONE or BUSY per REQ-021, otherwise go to IDLE.
REQ-025 Non-MUL latency: out_valid SHALL rise 1 cycle after acceptance, giving one op per cycle under continuous out_ready.
REQ-026 MUL latency: out_valid SHALL rise WIDTH+1 cycles after acceptance.
REQ-027 in_ready SHALL depend combinationally only on state and out_ready, never on in_valid.
REQ-028 opsel, a and b SHALL be ignored when not accepted; operand changes after acceptance SHALL NOT affect the result in flight.

Reset
REQ-029 On reset: state=IDLE, out_valid=0, result=0, zero=0, carry=0, err=0; in_ready=1 from the first cycle after reset.
REQ-030 Reset SHALL abort any in-flight MUL or pending result, which is discarded with no output, and SHALL take priority over a simultaneous accept.

Configuration
REQ-031 Macro ALU_PIPE_MUL_EN defined: MUL SHALL behave per REQ-016, REQ-022 and REQ-026.
REQ-032 Macro ALU_PIPE_MUL_EN undefined: no multiplier or BUSY logic is built; opcode 14 SHALL behave as illegal per REQ-017.

Verification
REQ-033 WIDTH=32, ADD a=0xFFFFFFFF b=1 -> next cycle out_valid=1, result=0, zero=1, carry=1, err=0.
REQ-034 SUB a=3 b=5 -> result=0xFFFFFFFE, carry=1; then SRA a=0x80000000 b=4 -> result=0xF8000000.
REQ-035 MUL a=0x12345 b=0x100 with ALU_PIPE_MUL_EN defined -> in_ready=0 for 32 cycles, out_valid at acceptance+33, result=0x01234500; with macro undefined -> err=1 and result=0 after 1 cycle.
REQ-036 Back-to-back: 4 ops (AND, MVHI b=0xABCD, SLT a=-1 b=1, opcode 15) with out_ready held 0 for 5 cycles, then 1 -> first result held stable, one result per cycle after release: ..., 0xABCD0000, 1, err=1.
REQ-037 Reset asserted mid-MUL at BUSY cycle 10 -> next cycle IDLE, out_valid=0, in_ready=1, and no stale result ever appears.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe -- single-issue pipelined ALU with valid/ready handshakes on both sides.
//
// An operation is captured when in_valid && in_ready. Most opcodes produce their
// result one cycle later. MUL is an iterative shift-add multiplier that retires one
// multiplier bit per cycle, so its result appears WIDTH+1 cycles after acceptance.
// A result stays on the outputs until the consumer takes it with out_ready. While a
// result is being taken, a new request can be accepted in the same cycle.
//
// Build option:
//   ALU_PIPE_MUL_EN  defined   -> opcode 14 is MUL (shift-add, WIDTH cycles in BUSY)
//                    undefined -> no multiplier is built; opcode 14 is illegal
//
// Parameters:
//   WIDTH      datapath width; must be even and >= 8
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   reset      synchronous active-high reset
//   in_valid   request present
//   in_ready   block can accept a request this cycle (depends only on state, out_ready)
//   opsel      operation select (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR,
//              7 XNOR, 8 MVHI, 9 SLL, 10 SRL, 11 SRA, 12 SLT, 13 SLTU, 14 MUL, 15 illegal)
//   a, b       operands
//   out_valid  result/zero/carry/err hold a valid result
//   out_ready  consumer accepts the result
//   result     result value
//   zero       result == 0
//   carry      ADD carry-out, SUB borrow (a < b unsigned), else 0
//   err        illegal opcode
module alu_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NAND = 4'd5,
        OP_NOR  = 4'd6,
        OP_XNOR = 4'd7,
        OP_MVHI = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11,
        OP_SLT  = 4'd12,
        OP_SLTU = 4'd13,
        OP_MUL  = 4'd14,
        OP_ILL  = 4'd15
    } op_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             is_mul;
    logic             load_alu;
    logic             start_mul;
    logic             mul_last;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_err;
    logic [WIDTH:0]   sum_ext;
    logic [SHW-1:0]   shamt;

    // ------------------------------------------------------------------
    // Single-cycle ALU, evaluated on the live operands at acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        sum_ext   = {1'b0, a} + {1'b0, b};
        shamt     = b[SHW-1:0];
        case (opsel)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = a - b;
                alu_carry = (a < b);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NAND: alu_res = ~(a & b);
            OP_NOR:  alu_res = ~(a | b);
            OP_XNOR: alu_res = ~(a ^ b);
            OP_MVHI: alu_res = {b[HALF-1:0], {HALF{1'b0}}};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            // OP_MUL only reaches this path when the multiplier is not built,
            // in which case it is reported exactly like OP_ILL.
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    assign is_mul = (opsel == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM: state register + next-state/handshake logic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        state_nxt = state;
        load_alu  = 1'b0;
        start_mul = 1'b0;

        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase

        accept = in_valid && in_ready;

        if (accept) begin
            if (is_mul) begin
                state_nxt = BUSY;
                start_mul = 1'b1;
            end else begin
                state_nxt = DONE;
                load_alu  = 1'b1;
            end
        end else if (state == DONE && out_ready) begin
            state_nxt = IDLE;
        end else if (state == BUSY) begin
`ifdef ALU_PIPE_MUL_EN
            if (mul_last) begin
                state_nxt = DONE;
            end
`else
            state_nxt = IDLE;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Iterative multiplier: multiplicand shifts left, multiplier shifts
    // right, one partial product folded into the accumulator per cycle.
    // The final cycle's sum is written straight into the result register.
    // ------------------------------------------------------------------
`ifdef ALU_PIPE_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_sum;
    logic [SHW-1:0]   cnt;

    assign mul_sum  = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (state == BUSY) && (cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start_mul) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
        end
    end
`else
    assign mul_last = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output registers: loaded only when a result is produced, so they
    // hold steady through DONE until the consumer takes them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else if (load_alu) begin
            result <= alu_res;
            zero   <= (alu_res == '0);
            carry  <= alu_carry;
            err    <= alu_err;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (mul_last) begin
            result <= mul_sum;
            zero   <= (mul_sum == '0);
            carry  <= 1'b0;
            err    <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- directed self-checking bench for alu_pipe (WIDTH=32).
// MUL expectations follow the ALU_PIPE_MUL_EN build option.
module tb_alu_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opsel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         err;

    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opsel     (opsel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r,
                           input logic z, input logic c, input logic e);
        chk1({tag, ".valid"}, out_valid, 1'b1);
        chk ({tag, ".result"}, result, r);
        chk1({tag, ".zero"}, zero, z);
        chk1({tag, ".carry"}, carry, c);
        chk1({tag, ".err"}, err, e);
    endtask

    // One isolated non-MUL operation: accept, scramble operands, check the
    // result twice (held while out_ready=0), then release back to IDLE.
    task automatic op1(input string tag, input logic [3:0] op,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] r, input logic z, input logic c, input logic e);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        opsel     = op;
        a         = aa;
        b         = bb;
        tick();
        in_valid = 1'b0;
        opsel    = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
        chk_out(tag, r, z, c, e);
        chk1({tag, ".in_ready_held"}, in_ready, 1'b0);
        tick();
        chk ({tag, ".held"}, result, r);
        out_ready = 1'b1;
        tick();
        chk1({tag, ".released"}, out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opsel     = 4'd0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk1("rst.valid", out_valid, 1'b0);
        chk ("rst.result", result, 32'h0);
        chk1("rst.zero", zero, 1'b0);
        chk1("rst.carry", carry, 1'b0);
        chk1("rst.err", err, 1'b0);
        reset = 1'b0;
        tick();
        chk1("rst.in_ready", in_ready, 1'b1);

        // Single operations
        op1("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        op1("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        op1("sub_neg",  4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
        op1("sub_eq",   4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        op1("sra",      4'd11, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        op1("srl_amt",  4'd10, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        op1("sll_max",  4'd9,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        op1("or",       4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1'b0);
        op1("xor",      4'd4,  32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0, 1'b0, 1'b0);
        op1("nand",     4'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        op1("nor",      4'd6,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        op1("xnor",     4'd7,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        op1("mvhi",     4'd8,  32'h5555_5555, 32'hFFFF_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0);
        op1("sltu",     4'd13, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        op1("slt_neg",  4'd12, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        op1("illegal",  4'd15, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

`ifdef ALU_PIPE_MUL_EN
        // MUL: 32 cycles of in_ready=0, result on the 33rd cycle
        in_valid = 1'b1;
        opsel    = 4'd14;
        a        = 32'h0001_2345;
        b        = 32'h0000_0100;
        tick();
        opsel = 4'd0;
        a     = $urandom;
        b     = $urandom;
        for (int k = 1; k <= 32; k++) begin
            chk1("mul.busy_ready", in_ready, 1'b0);
            chk1("mul.busy_valid", out_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk_out("mul", 32'h0123_4500, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mul.held", result, 32'h0123_4500);
        out_ready = 1'b1;
        tick();
        chk1("mul.released", out_valid, 1'b0);
        out_ready = 1'b0;

        in_valid = 1'b1;
        opsel    = 4'd14;
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        repeat (32) tick();
        chk_out("mul_ones", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`else
        op1("mul_off", 4'd14, 32'h0001_2345, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`endif

        // Back-to-back with a stalled consumer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        opsel     = 4'd2;
        a         = 32'hFF00_FF00;
        b         = 32'h0FF0_0FF0;
        tick();
        opsel = 4'd8;
        a     = $urandom;
        b     = 32'h0000_ABCD;
        for (int k = 0; k < 5; k++) begin
            chk_out("b2b.and_hold", 32'h0F00_0F00, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b0;
            #1;
            chk1("b2b.ready_nov", in_ready, 1'b0);
            in_valid = 1'b1;
            #1;
            chk1("b2b.ready_v", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk1("b2b.ready_rel", in_ready, 1'b1);
        tick();
        chk_out("b2b.mvhi", 32'hABCD_0000, 1'b0, 1'b0, 1'b0);
        opsel = 4'd12;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0001;
        tick();
        chk_out("b2b.slt", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        opsel = 4'd15;
        a     = $urandom;
        b     = $urandom;
        tick();
        chk_out("b2b.ill", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick();
        chk1("b2b.idle_valid", out_valid, 1'b0);
        chk1("b2b.idle_ready", in_ready, 1'b1);
        out_ready = 1'b0;

        // Reset beats a simultaneous accept
        in_valid = 1'b1;
        opsel    = 4'd0;
        a        = 32'h0000_0001;
        b        = 32'h0000_0001;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk1("rst_acc.valid", out_valid, 1'b0);
        chk ("rst_acc.result", result, 32'h0);
        tick();
        chk1("rst_acc.valid2", out_valid, 1'b0);

        // Reset discards a pending result
        in_valid = 1'b1;
        opsel    = 4'd0;
        a        = 32'h0000_0002;
        b        = 32'h0000_0003;
        tick();
        in_valid = 1'b0;
        chk_out("pend", 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("pend_rst.valid", out_valid, 1'b0);
        chk1("pend_rst.ready", in_ready, 1'b1);
        chk ("pend_rst.result", result, 32'h0);

`ifdef ALU_PIPE_MUL_EN
        // Reset during BUSY cycle 10 aborts the multiply
        out_ready = 1'b1;
        in_valid  = 1'b1;
        opsel     = 4'd14;
        a         = 32'h0000_0003;
        b         = 32'h0000_0007;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        chk1("mulrst.busy", in_ready, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("mulrst.valid", out_valid, 1'b0);
        chk1("mulrst.ready", in_ready, 1'b1);
        chk ("mulrst.result", result, 32'h0);
        out_ready = 1'b0;
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            tick();
        end
        chk("mulrst.no_stale", seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
